mac_poly_engine: RTL and testbench
==================================

MAC_POLY_ENGINE -- requirements
Module: mac_poly_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 8, operand width (unsigned).
REQ-002 SHALL have parameter ACC_W, default 24, accumulator/result width; ACC_W >= 2*DATA_W.
REQ-003 SHALL have parameter CNT_W, default 8, beat counter width.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low (0 = reset).
REQ-006 SHALL have port mode  input  1  0 = sum-of-products, 1 = Horner polynomial; sampled on first beat only.
REQ-007 SHALL have port valid_input  input  1  beat valid.
REQ-008 SHALL have port ready_input  output  1  engine accepts a beat.
REQ-009 SHALL have port last_input  input  1  final beat of packet.
REQ-010 SHALL have port num_a  input  DATA_W  SOP multiplicand / Horner coefficient.
REQ-011 SHALL have port num_x  input  DATA_W  SOP multiplier / Horner evaluation point (first beat only).
REQ-012 SHALL have port valid_output  output  1  result valid.
REQ-013 SHALL have port ready_output  input  1  consumer accepts result.
REQ-014 SHALL have port final_output  output  ACC_W  packet result.
REQ-015 SHALL have port overflow  output  1  result wrapped modulo 2^ACC_W.
REQ-016 SHALL have port beat_count  output  CNT_W  beats accepted in the packet.

Function
REQ-017 SHALL treat a beat as accepted when valid_input && ready_input at a rising edge.
REQ-018 SHALL implement FSM states IDLE, ACCUM, DONE; IDLE->ACCUM on accepted non-last first beat; IDLE or ACCUM->DONE on accepted last beat; DONE->IDLE when valid_output && ready_output.
REQ-019 SHALL drive ready_input = 1 in IDLE and ACCUM, 0 in DONE.
REQ-020 SHALL latch mode and num_x on the first beat; mode/num_x changes during ACCUM SHALL be ignored.
REQ-021 SOP mode: first beat acc = a*x; each later beat acc = acc + a*x (x from same beat).
REQ-022 Horner mode: first beat acc = a; each later beat acc = acc*x_latched + a; beats a,b,c yield (a*x+b)*x+c.
REQ-023 SHALL update acc on the accepting edge; no pipeline bubbles; back-to-back beats allowed every cycle.
REQ-024 SHALL assert valid_output the cycle after the last beat is accepted (latency 1) with final_output = acc.
REQ-025 SHALL hold valid_output, final_output, overflow, beat_count stable while valid_output && !ready_output.
REQ-026 SHALL truncate all arithmetic modulo 2^ACC_W and set overflow (sticky per packet) if any discarded product or carry bit is nonzero.
REQ-027 SHALL increment beat_count per accepted beat, saturating at 2^CNT_W-1; arithmetic continues past saturation.
REQ-028 SHALL clear acc, overflow, beat_count on the first beat of each new packet.
REQ-029 SHALL ignore valid_input while in DONE; a beat offered on the DONE->IDLE edge SHALL NOT be accepted.
REQ-030 SHALL ignore ready_output while valid_output = 0.

Reset
REQ-031 SHALL, while reset = 0, force state IDLE, valid_output = 0, final_output = 0, overflow = 0, beat_count = 0, acc = 0.
REQ-032 SHALL drive ready_input = 0 during reset and 1 from the first edge after reset release.
REQ-033 SHALL discard any partial packet on reset assertion; no result SHALL be produced for it.

Verification
REQ-034 Horner: mode=1, beats (a=5,x=3),(a=2),(a=1,last) in consecutive cycles -> valid_output 1 cycle later, final_output=52, overflow=0, beat_count=3.
REQ-035 SOP: mode=0, beats (9,8),(7,6,last) -> final_output=114, beat_count=2; single beat (255,255,last) -> 65025 one cycle after acceptance.
REQ-036 Backpressure: ready_output=0 for 3 cycles after result -> valid_output held, final_output stable, ready_input=0, offered beats not accepted; ready_output=1 -> IDLE next cycle.
REQ-037 Overflow: ACC_W=16, mode=1, x=255, coefficients 255,255,255 -> final_output=511, overflow=1; next packet (1,1,last) mode=0 -> 1, overflow=0.
REQ-038 Reset mid-packet: two SOP beats accepted, reset=0 one cycle -> all outputs 0; new packet (3,4,last) -> 12, beat_count=1.
REQ-039 Mode toggled during ACCUM of Horner packet -> result unchanged versus constant-mode run.

Source files
------------

// File: rtl/mac_poly_engine.sv
// rtl/mac_poly_engine.sv - streaming multiply-accumulate / Horner polynomial engine
//
// Purpose:
//   Consumes a packet of operand beats and produces one result per packet.
//   mode=0 : sum of products, acc = sum(a_i * x_i)
//   mode=1 : Horner evaluation, acc = (...((a0*x + a1)*x + a2)...), x taken
//            from the first beat of the packet.
//   All arithmetic wraps modulo 2^ACC_W; overflow flags any lost bits.
//
// Ports:
//   clk           : clock, rising edge
//   reset         : asynchronous reset, active low
//   mode          : operation select, sampled on the first beat
//   valid_input   : input beat valid
//   ready_input   : engine can accept a beat
//   last_input    : beat is the final one of the packet
//   num_a         : multiplicand (SOP) / coefficient (Horner)
//   num_x         : multiplier (SOP) / evaluation point (Horner, first beat)
//   valid_output  : result valid
//   ready_output  : consumer takes the result
//   final_output  : packet result
//   overflow      : sticky wrap indicator for the packet
//   beat_count    : saturating count of accepted beats in the packet
module mac_poly_engine #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mode,
  input  logic              valid_input,
  output logic              ready_input,
  input  logic              last_input,
  input  logic [DATA_W-1:0] num_a,
  input  logic [DATA_W-1:0] num_x,
  output logic              valid_output,
  input  logic              ready_output,
  output logic [ACC_W-1:0]  final_output,
  output logic              overflow,
  output logic [CNT_W-1:0]  beat_count
);

  // Width that holds acc*x + a without loss.
  localparam int WW = ACC_W + DATA_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic                ovf_q, ovf_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                mode_q, mode_d;
  logic [DATA_W-1:0]   x_q, x_d;
  // Held low through reset so ready_input only rises on the first clock
  // edge after reset is released.
  logic                rdy_en_q, rdy_en_d;

  logic                accept;
  logic [2*DATA_W-1:0] prod;
  logic [ACC_W:0]      sop_wide;
  logic [WW-1:0]       horner_wide;
  logic [CNT_W-1:0]    cnt_inc;

  assign ready_input  = rdy_en_q && (state_q != DONE);
  assign accept       = valid_input && ready_input;
  assign valid_output = (state_q == DONE);
  assign final_output = acc_q;
  assign overflow     = ovf_q;
  assign beat_count   = cnt_q;

  // Products never exceed 2*DATA_W bits, which fits in ACC_W, so only the
  // accumulate carry can be lost in SOP mode.
  assign prod        = (2*DATA_W)'(num_a) * (2*DATA_W)'(num_x);
  assign sop_wide    = {1'b0, acc_q} + (ACC_W+1)'(prod);
  // Horner step computed at full width; any bit above ACC_W means either the
  // product or the following add wrapped.
  assign horner_wide = WW'(acc_q) * WW'(x_q) + WW'(num_a);
  assign cnt_inc     = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    x_d      = x_q;
    rdy_en_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (accept) begin
          mode_d  = mode;
          x_d     = num_x;
          acc_d   = mode ? ACC_W'(num_a) : ACC_W'(prod);
          ovf_d   = 1'b0;
          cnt_d   = CNT_W'(1);
          state_d = last_input ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          if (mode_q) begin
            acc_d = horner_wide[ACC_W-1:0];
            ovf_d = ovf_q | (|horner_wide[WW-1:ACC_W]);
          end else begin
            acc_d = sop_wide[ACC_W-1:0];
            ovf_d = ovf_q | sop_wide[ACC_W];
          end
          cnt_d   = cnt_inc;
          state_d = last_input ? DONE : ACCUM;
        end
      end
      DONE: begin
        if (ready_output) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      x_q      <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      x_q      <= x_d;
      rdy_en_q <= rdy_en_d;
    end
  end

endmodule

// File: tb/tb_mac_poly_engine.sv
// tb/tb_mac_poly_engine.sv - scoreboard bench for mac_poly_engine
module tb_mac_poly_engine;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;
  localparam int CNT_W  = 3;

  logic              clk;
  logic              rst_n;
  logic              mode;
  logic              valid_input;
  logic              ready_input;
  logic              last_input;
  logic [DATA_W-1:0] num_a;
  logic [DATA_W-1:0] num_x;
  logic              valid_output;
  logic              ready_output;
  logic [ACC_W-1:0]  final_output;
  logic              overflow;
  logic [CNT_W-1:0]  beat_count;

  int checks;
  int failures;

  typedef struct {
    logic [ACC_W-1:0] res;
    logic             ovf;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  mac_poly_engine #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (rst_n),
    .mode        (mode),
    .valid_input (valid_input),
    .ready_input (ready_input),
    .last_input  (last_input),
    .num_a       (num_a),
    .num_x       (num_x),
    .valid_output(valid_output),
    .ready_output(ready_output),
    .final_output(final_output),
    .overflow    (overflow),
    .beat_count  (beat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic expect_result(input logic [ACC_W-1:0] res, input logic ovf, input logic [CNT_W-1:0] cnt);
    exp_t e;
    e.res = res;
    e.ovf = ovf;
    e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  // Monitor: every result handed over is popped against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && valid_output && ready_output) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual=%0d required=none", final_output);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result", 32'(final_output), 32'(e.res));
        check("overflow", 32'(overflow), 32'(e.ovf));
        check("beat_count", 32'(beat_count), 32'(e.cnt));
      end
    end
  end

  task automatic beat(input logic m, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] x, input logic l);
    mode        = m;
    num_a       = a;
    num_x       = x;
    last_input  = l;
    valid_input = 1'b1;
    @(posedge clk);
    #1;
    valid_input = 1'b0;
    last_input  = 1'b0;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!ready_input && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!ready_input) check("wait_ready_timeout", 32'(ready_input), 32'd1);
  endtask

  task automatic latency_check();
    check("latency_valid", 32'(valid_output), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    checks       = 0;
    failures     = 0;
    rst_n        = 1'b0;
    mode         = 1'b0;
    valid_input  = 1'b0;
    last_input   = 1'b0;
    num_a        = '0;
    num_x        = '0;
    ready_output = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ready_input", 32'(ready_input), 32'd0);
    check("rst_valid_output", 32'(valid_output), 32'd0);
    check("rst_final_output", 32'(final_output), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_beat_count", 32'(beat_count), 32'd0);
    rst_n = 1'b1;
    #1;
    check("release_ready_before_edge", 32'(ready_input), 32'd0);
    @(posedge clk);
    #1;
    check("release_ready_after_edge", 32'(ready_input), 32'd1);

    // Horner x=3: (5*3+2)*3+1 = 52
    expect_result(16'd52, 1'b0, 3'd3);
    beat(1'b1, 8'd5, 8'd3, 1'b0);
    beat(1'b1, 8'd2, 8'd0, 1'b0);
    beat(1'b1, 8'd1, 8'd0, 1'b1);
    latency_check();
    wait_ready();

    // SOP: 9*8 + 7*6 = 114
    expect_result(16'd114, 1'b0, 3'd2);
    beat(1'b0, 8'd9, 8'd8, 1'b0);
    beat(1'b0, 8'd7, 8'd6, 1'b1);
    latency_check();
    wait_ready();

    // Single beat 255*255 = 65025
    expect_result(16'd65025, 1'b0, 3'd1);
    beat(1'b0, 8'd255, 8'd255, 1'b1);
    latency_check();
    wait_ready();

    // Backpressure: Horner x=2: 1*2+3 = 5, held three cycles with beats offered
    expect_result(16'd5, 1'b0, 3'd2);
    ready_output = 1'b0;
    beat(1'b1, 8'd1, 8'd2, 1'b0);
    beat(1'b1, 8'd3, 8'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("bp_valid_held", 32'(valid_output), 32'd1);
      check("bp_final_stable", 32'(final_output), 32'd5);
      check("bp_count_stable", 32'(beat_count), 32'd2);
      check("bp_ready_input_low", 32'(ready_input), 32'd0);
      mode        = 1'b0;
      num_a       = 8'd99;
      num_x       = 8'd1;
      last_input  = 1'b1;
      valid_input = 1'b1;
      @(posedge clk);
      #1;
    end
    check("bp_valid_still_held", 32'(valid_output), 32'd1);
    check("bp_final_still_stable", 32'(final_output), 32'd5);
    ready_output = 1'b1;
    @(posedge clk);
    #1;
    // A beat offered on the DONE->IDLE edge must not have been taken.
    check("bp_idle_valid_low", 32'(valid_output), 32'd0);
    check("bp_idle_ready_high", 32'(ready_input), 32'd1);
    valid_input = 1'b0;
    last_input  = 1'b0;

    // Horner overflow, ACC_W=16, x=255: 16646655 mod 65536 = 511
    expect_result(16'd511, 1'b1, 3'd3);
    beat(1'b1, 8'd255, 8'd255, 1'b0);
    beat(1'b1, 8'd255, 8'd0, 1'b0);
    beat(1'b1, 8'd255, 8'd0, 1'b1);
    wait_ready();

    // Overflow cleared on next packet
    expect_result(16'd1, 1'b0, 3'd1);
    beat(1'b0, 8'd1, 8'd1, 1'b1);
    wait_ready();

    // SOP carry: 2*65025 = 130050 mod 65536 = 64514
    expect_result(16'd64514, 1'b1, 3'd2);
    beat(1'b0, 8'd255, 8'd255, 1'b0);
    beat(1'b0, 8'd255, 8'd255, 1'b1);
    wait_ready();

    // Reset mid-packet: partial packet produces nothing
    beat(1'b0, 8'd2, 8'd2, 1'b0);
    beat(1'b0, 8'd3, 8'd3, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(valid_output), 32'd0);
    check("midrst_final", 32'(final_output), 32'd0);
    check("midrst_overflow", 32'(overflow), 32'd0);
    check("midrst_count", 32'(beat_count), 32'd0);
    check("midrst_ready", 32'(ready_input), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    expect_result(16'd12, 1'b0, 3'd1);
    beat(1'b0, 8'd3, 8'd4, 1'b1);
    wait_ready();

    // Mode/x toggled during ACCUM: Horner x=2: (3*2+1)*2+4 = 18
    expect_result(16'd18, 1'b0, 3'd3);
    beat(1'b1, 8'd3, 8'd2, 1'b0);
    beat(1'b0, 8'd1, 8'd7, 1'b0);
    beat(1'b0, 8'd4, 8'd9, 1'b1);
    wait_ready();
    expect_result(16'd18, 1'b0, 3'd3);
    beat(1'b1, 8'd3, 8'd2, 1'b0);
    beat(1'b1, 8'd1, 8'd2, 1'b0);
    beat(1'b1, 8'd4, 8'd2, 1'b1);
    wait_ready();

    // Beat counter saturates at 7 while arithmetic continues: 9 beats of 1*1
    expect_result(16'd9, 1'b0, 3'd7);
    for (int i = 0; i < 9; i++) begin
      beat(1'b0, 8'd1, 8'd1, (i == 8));
    end
    wait_ready();

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
